// File: rtl/piso_serializer_if.sv
// Handshake bundle for piso_serializer: parallel words in on one valid/ready
// pair, serial slices out on a second.
interface piso_serializer_if #(
  parameter int SIZE_DATA_IN  = 8,
  parameter int SIZE_DATA_OUT = 1
);
  logic [SIZE_DATA_IN-1:0]  i_data;
  logic                     i_valid;
  logic                     o_ready;
  logic [SIZE_DATA_OUT-1:0] o_data;
  logic                     o_valid;
  logic                     i_ready;
  logic                     o_last;
  logic                     o_busy;

  modport slave (
    input  i_data, i_valid, i_ready,
    output o_ready, o_data, o_valid, o_last, o_busy
  );

  modport master (
    output i_data, i_valid, i_ready,
    input  o_ready, o_data, o_valid, o_last, o_busy
  );
endinterface

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out serializer, LSB slice first, with a one-word pending
// buffer so back-to-back words stream without bubbles.
module piso_serializer #(
  parameter int SIZE_DATA_IN  = 8,
  parameter int SIZE_DATA_OUT = 1
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_flush,
  piso_serializer_if.slave      bus
);
  localparam int DEPTH = SIZE_DATA_IN / SIZE_DATA_OUT;
  localparam int CNT_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEPTH - 1);

  typedef enum logic [1:0] {EMPTY, SHIFT, FULL} state_t;

  state_t                   r_state, w_state_nxt;
  logic [CNT_W-1:0]         r_cnt, w_cnt_nxt;
  logic [SIZE_DATA_IN-1:0]  r_active, w_active_nxt;
  logic [SIZE_DATA_IN-1:0]  r_pending, w_pending_nxt;

  logic                     w_valid;
  logic                     w_ready;
  logic                     w_accept;
  logic                     w_send;
  logic                     w_last_send;
  logic [SIZE_DATA_OUT-1:0] w_slice;

  // Handshake outputs come from state alone, so o_ready has no path from i_valid/i_ready.
  assign w_valid     = (r_state != EMPTY);
  assign w_ready     = (r_state != FULL);
  assign w_accept    = bus.i_valid & w_ready;
  assign w_send      = w_valid & bus.i_ready;
  assign w_last_send = w_send & (r_cnt == LAST_CNT);
  assign w_slice     = SIZE_DATA_OUT'(r_active >> (int'(r_cnt) * SIZE_DATA_OUT));

  assign bus.o_valid = w_valid;
  assign bus.o_ready = w_ready;
  assign bus.o_busy  = w_valid;
  assign bus.o_last  = w_valid & (r_cnt == LAST_CNT);
  assign bus.o_data  = w_valid ? w_slice : '0;

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_active_nxt  = r_active;
    w_pending_nxt = r_pending;

    // Explicit wrap compare keeps non-power-of-two DEPTH correct.
    if (w_send) begin
      w_cnt_nxt = (r_cnt == LAST_CNT) ? '0 : r_cnt + 1'b1;
    end

    case (r_state)
      EMPTY: begin
        if (w_accept) begin
          w_active_nxt = bus.i_data;
          w_cnt_nxt    = '0;
          w_state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (w_last_send && w_accept) begin
          w_active_nxt = bus.i_data;
        end else if (w_last_send) begin
          w_state_nxt = EMPTY;
        end else if (w_accept) begin
          w_pending_nxt = bus.i_data;
          w_state_nxt   = FULL;
        end
      end
      FULL: begin
        if (w_last_send) begin
          w_active_nxt = r_pending;
          w_state_nxt  = SHIFT;
        end
      end
      default: w_state_nxt = EMPTY;
    endcase

    // Flush discards both words and any transfer seen this cycle.
    if (i_flush) begin
      w_state_nxt   = EMPTY;
      w_cnt_nxt     = '0;
      w_active_nxt  = '0;
      w_pending_nxt = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state   <= EMPTY;
      r_cnt     <= '0;
      r_active  <= '0;
      r_pending <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_active  <= w_active_nxt;
      r_pending <= w_pending_nxt;
    end
  end
endmodule

// File: doc/piso_serializer.md
# piso_serializer

Parallel-in/serial-out serializer for the Viterbi datapath: accepts SIZE_DATA_IN-bit words over a valid/ready handshake and emits them as SIZE_DATA_OUT-bit slices, least-significant slice first, over a second valid/ready handshake. It feeds the serial bit stream into the encoder and channel model, and its slice order is the one the serial-to-parallel collector expects, so a loopback returns the original word. A one-word pending buffer lets the next word be accepted while the current one is shifting, so the stream has no bubbles between words.

## Interface
- SIZE_DATA_IN, 8, parallel word width
- SIZE_DATA_OUT, 1, serial slice width; DEPTH = SIZE_DATA_IN/SIZE_DATA_OUT must be an integer ≥ 2
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_flush  in  1  synchronous clear, highest priority after reset
- i_data  in  SIZE_DATA_IN  parallel word
- i_valid  in  1  upstream word valid
- o_ready  out  1  upstream may transfer; depends on state only, no combinational path from i_valid/i_ready
- o_data  out  SIZE_DATA_OUT  current slice; 0 when o_valid=0
- o_valid  out  1  o_data valid
- i_ready  in  1  downstream accepts slice
- o_last  out  1  o_valid and current slice is DEPTH-1
- o_busy  out  1  state != EMPTY

## Operation
- Storage: active word register, slice counter cnt (width $clog2(DEPTH)), pending word register.
- Upstream transfer ("accept"): i_valid & o_ready at a rising edge. Downstream transfer ("send"): o_valid & i_ready.
- cnt advances on send only. The wrap from DEPTH-1 to 0 uses an explicit compare, not overflow, so DEPTH need not be a power of two.
- o_data = active[cnt*SIZE_DATA_OUT +: SIZE_DATA_OUT] when o_valid=1, else 0.
- FSM states:
  - EMPTY: o_valid=0, o_ready=1.
  - SHIFT: active word valid, pending empty; o_valid=1, o_ready=1.
  - FULL: active and pending valid; o_valid=1, o_ready=0.
- EMPTY + accept: active<=i_data, cnt<=0, go to SHIFT.
- SHIFT:
  - send of last slice + accept: active<=i_data, cnt<=0, stay in SHIFT.
  - send of last slice, no accept: go to EMPTY.
  - accept while not on last-slice send: pending<=i_data, go to FULL. cnt still advances if a send occurs.
- FULL:
  - send of last slice: active<=pending, cnt<=0, go to SHIFT.
  - No accept is possible in FULL.
- Backpressure: while o_valid & ~i_ready, o_data, o_last and cnt are held stable. No slice is dropped or duplicated.
- i_flush=1: next state EMPTY, cnt<=0, active and pending <=0. Any accept or send in that cycle is discarded; the upstream word is dropped even though o_ready=1.

## Timing
- Reset values (asynchronous): state EMPTY, cnt 0, registers 0, o_valid 0, o_last 0, o_data 0, o_busy 0, o_ready 1.
- Reset asserted mid-word discards both active and pending words immediately.
- Latency: slice 0 appears on o_data in the cycle after the accept edge.
- With i_ready held high, a word occupies exactly DEPTH consecutive o_valid cycles.
- Throughput: words accepted early enough stream with zero idle cycles between them.
- o_ready drops the cycle after a word enters pending and rises the cycle after pending moves to active.
- o_busy falls the cycle after the last send if no new word was accepted.

## Test plan
- Reset, then word 8'hA5 with i_ready=1 → o_data 1,0,1,0,0,1,0,1 on 8 consecutive cycles starting 1 cycle after accept; o_last only on the 8th; o_busy low after.
- Words 8'h01, 8'h80, 8'hFF offered back-to-back, i_ready=1 → 24 contiguous o_valid cycles with the correct LSB-first bits; o_ready low while pending is full; no gaps.
- Word 8'h5A, i_ready low for 5 cycles at slice 3 → o_data/cnt frozen, then remaining slices 1,0,1,0 delivered; 8 sends total.
- Accept arriving in the same cycle as the last-slice send in SHIFT → new word's slice 0 on the next cycle, no bubble, state stays SHIFT.
- i_flush at slice 4 with pending full → next cycle o_valid=0, o_busy=0, o_ready=1; then word 8'h3C serializes as 0,0,1,1,1,1,0,0.
- SIZE_DATA_OUT=2, word 8'hE4 → slices 0,1,2,3. Separately, async reset asserted mid-word → all outputs at reset values immediately, with no residual slices after release.
